// File: rtl/filter_seq_pkg.sv
// Shared types and constants for the 3x3 filter memory-to-memory sequencer.
// Holds the FSM encoding, CSR map, window geometry and pixel/result field positions.
package filter_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StPush,
    StSettle,
    StCollect,
    StStore,
    StAdvance,
    StDone
  } seq_state_e;

  localparam logic [2:0] CsrCtrl       = 3'd0;
  localparam logic [2:0] CsrStatus     = 3'd1;
  localparam logic [2:0] CsrSrcBase    = 3'd2;
  localparam logic [2:0] CsrDstBase    = 3'd3;
  localparam logic [2:0] CsrWidth      = 3'd4;
  localparam logic [2:0] CsrHeight     = 3'd5;
  localparam logic [2:0] CsrPixelsDone = 3'd6;

  localparam int unsigned CtrlStart   = 0;
  localparam int unsigned CtrlIrqEn   = 1;
  localparam int unsigned StatusBusy  = 0;
  localparam int unsigned StatusDone  = 1;
  localparam int unsigned StatusError = 2;

  localparam int unsigned WINDOW_LEN = 9;
  localparam logic [3:0]  LastK      = 4'(WINDOW_LEN - 1);
  // Filter result register sits just above the nine window registers.
  localparam logic [3:0]  FltResultAddr = 4'd9;

  localparam int unsigned PixelMsb = 23;  // {8'h00, B, G, R}
  localparam int unsigned ResultW  = 8;

  function automatic logic [1:0] win_row(logic [3:0] k);
    unique case (k)
      4'd0, 4'd1, 4'd2: win_row = 2'd0;
      4'd3, 4'd4, 4'd5: win_row = 2'd1;
      default:          win_row = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] win_col(logic [3:0] k);
    unique case (k)
      4'd0, 4'd3, 4'd6: win_col = 2'd0;
      4'd1, 4'd4, 4'd7: win_col = 2'd1;
      default:          win_col = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Incremental address generator: tracks the current window's top-left pointer and the
// destination pointer, and produces the source address of window element k.
module window_addr_gen
  import filter_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [3:0]        k,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              last_pixel
);

  logic [ADDR_W-1:0] row_ptr_q, col_off_q, dst_ptr_q;
  logic [DIM_W-1:0]  xc_q, yc_q;
  logic [ADDR_W-1:0] stride, row_off, col_k;
  logic              last_x, last_y;

  assign stride = ADDR_W'({width, 2'b00});
  assign col_k  = ADDR_W'({win_col(k), 2'b00});

  always_comb begin
    row_off = '0;
    case (win_row(k))
      2'd0:    row_off = '0;
      2'd1:    row_off = stride;
      default: row_off = stride << 1;
    endcase
  end

  assign fetch_addr = row_ptr_q + row_off + col_off_q + col_k;
  assign dst_addr   = dst_ptr_q;
  // xc/yc count interior columns/rows from zero, so the last one is dimension-3.
  assign last_x     = (xc_q == width - DIM_W'(3));
  assign last_y     = (yc_q == height - DIM_W'(3));
  assign last_pixel = last_x && last_y;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_ptr_q <= '0;
      col_off_q <= '0;
      dst_ptr_q <= '0;
      xc_q      <= '0;
      yc_q      <= '0;
    end else if (init) begin
      row_ptr_q <= src_base;
      col_off_q <= '0;
      dst_ptr_q <= dst_base;
      xc_q      <= '0;
      yc_q      <= '0;
    end else if (step) begin
      dst_ptr_q <= dst_ptr_q + ADDR_W'(4);
      if (last_x) begin
        xc_q      <= '0;
        col_off_q <= '0;
        yc_q      <= yc_q + DIM_W'(1);
        row_ptr_q <= row_ptr_q + stride;
      end else begin
        xc_q      <= xc_q + DIM_W'(1);
        col_off_q <= col_off_q + ADDR_W'(4);
      end
    end
  end

endmodule

// File: rtl/filter_sequencer.sv
// Memory-to-memory scheduler for the 3x3 filter: fetches each window from the source frame,
// pushes it into the filter, collects the result and stores it in the destination frame.
module filter_sequencer
  import filter_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = 10,
  parameter int unsigned SETTLE = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        csr_address,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  input  logic              csr_read,
  output logic [31:0]       csr_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic [31:0]       mem_readdata,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic              mem_waitrequest,
  output logic [3:0]        flt_address,
  output logic              flt_write,
  output logic [31:0]       flt_writedata,
  output logic              flt_read,
  input  logic [31:0]       flt_readdata,
  input  logic              flt_waitrequest,
  output logic              busy,
  output logic              irq
);

  localparam logic [7:0] SettleLast = 8'((SETTLE > 0) ? SETTLE - 1 : 0);

  seq_state_e        state_q;
  logic [3:0]        k_q;
  logic [7:0]        settle_cnt_q;
  logic              done_q, error_q, irq_en_q, last_q;
  logic [ADDR_W-1:0] src_base_q, dst_base_q;
  logic [DIM_W-1:0]  width_q, height_q;
  logic [31:0]       pixels_done_q;

  logic              start_req, cfg_ok, gen_init, gen_step, last_pixel;
  logic [3:0]        gen_k;
  logic [ADDR_W-1:0] fetch_addr, dst_addr;
  logic              unused_bits;

  assign unused_bits = ^{mem_readdata[31:PixelMsb+1], flt_readdata[31:ResultW]};

  assign start_req = csr_write && (csr_address == CsrCtrl) && csr_writedata[CtrlStart] && !busy;
  assign cfg_ok    = (width_q >= DIM_W'(3)) && (height_q >= DIM_W'(3));
  assign gen_init  = start_req && cfg_ok;
  assign gen_step  = (state_q == StStore) && !mem_waitrequest;
  // Only PUSH looks ahead to k+1; ADVANCE always starts the next window at k=0.
  assign gen_k     = (state_q == StPush) ? k_q + 4'd1 : 4'd0;
  assign irq       = done_q & irq_en_q;

  window_addr_gen #(
    .ADDR_W(ADDR_W),
    .DIM_W (DIM_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .init      (gen_init),
    .step      (gen_step),
    .src_base  (src_base_q),
    .dst_base  (dst_base_q),
    .width     (width_q),
    .height    (height_q),
    .k         (gen_k),
    .fetch_addr(fetch_addr),
    .dst_addr  (dst_addr),
    .last_pixel(last_pixel)
  );

  always_comb begin
    csr_readdata = '0;
    if (csr_read) begin
      case (csr_address)
        CsrCtrl:       csr_readdata[CtrlIrqEn] = irq_en_q;
        CsrStatus:     csr_readdata[2:0] = {error_q, done_q, busy};
        CsrSrcBase:    csr_readdata = 32'(src_base_q);
        CsrDstBase:    csr_readdata = 32'(dst_base_q);
        CsrWidth:      csr_readdata = 32'(width_q);
        CsrHeight:     csr_readdata = 32'(height_q);
        CsrPixelsDone: csr_readdata = pixels_done_q;
        default:       csr_readdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      k_q           <= '0;
      settle_cnt_q  <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      irq_en_q      <= 1'b0;
      last_q        <= 1'b0;
      src_base_q    <= '0;
      dst_base_q    <= '0;
      width_q       <= '0;
      height_q      <= '0;
      pixels_done_q <= '0;
      busy          <= 1'b0;
      mem_address   <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= '0;
      flt_address   <= '0;
      flt_write     <= 1'b0;
      flt_writedata <= '0;
      flt_read      <= 1'b0;
    end else begin
      if (csr_write) begin
        case (csr_address)
          CsrCtrl: irq_en_q <= csr_writedata[CtrlIrqEn];
          CsrStatus: begin
            if (csr_writedata[StatusDone])  done_q  <= 1'b0;
            if (csr_writedata[StatusError]) error_q <= 1'b0;
          end
          CsrSrcBase: if (!busy) src_base_q <= ADDR_W'(csr_writedata);
          CsrDstBase: if (!busy) dst_base_q <= ADDR_W'(csr_writedata);
          CsrWidth:   if (!busy) width_q    <= csr_writedata[DIM_W-1:0];
          CsrHeight:  if (!busy) height_q   <= csr_writedata[DIM_W-1:0];
          default: ;
        endcase
      end

      // FSM updates follow the CSR writes so a DONE-cycle set beats a same-cycle W1C.
      case (state_q)
        StIdle: begin
          if (start_req) begin
            if (cfg_ok) begin
              busy          <= 1'b1;
              done_q        <= 1'b0;
              pixels_done_q <= '0;
              k_q           <= '0;
              mem_address   <= src_base_q;
              mem_read      <= 1'b1;
              state_q       <= StFetch;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        StFetch: begin
          if (!mem_waitrequest) begin
            mem_read      <= 1'b0;
            flt_writedata <= {8'h00, mem_readdata[PixelMsb:0]};
            flt_address   <= k_q;
            flt_write     <= 1'b1;
            state_q       <= StPush;
          end
        end
        StPush: begin
          if (!flt_waitrequest) begin
            flt_write <= 1'b0;
            if (k_q == LastK) begin
              if (SETTLE == 0) begin
                flt_address <= FltResultAddr;
                flt_read    <= 1'b1;
                state_q     <= StCollect;
              end else begin
                settle_cnt_q <= '0;
                state_q      <= StSettle;
              end
            end else begin
              k_q         <= k_q + 4'd1;
              mem_address <= fetch_addr;
              mem_read    <= 1'b1;
              state_q     <= StFetch;
            end
          end
        end
        StSettle: begin
          if (settle_cnt_q == SettleLast) begin
            flt_address <= FltResultAddr;
            flt_read    <= 1'b1;
            state_q     <= StCollect;
          end else begin
            settle_cnt_q <= settle_cnt_q + 8'd1;
          end
        end
        StCollect: begin
          if (!flt_waitrequest) begin
            flt_read      <= 1'b0;
            mem_writedata <= {24'h0, flt_readdata[ResultW-1:0]};
            mem_address   <= dst_addr;
            mem_write     <= 1'b1;
            state_q       <= StStore;
          end
        end
        StStore: begin
          if (!mem_waitrequest) begin
            mem_write     <= 1'b0;
            pixels_done_q <= pixels_done_q + 32'd1;
            last_q        <= last_pixel;
            state_q       <= StAdvance;
          end
        end
        StAdvance: begin
          if (last_q) begin
            state_q <= StDone;
          end else begin
            k_q         <= '0;
            mem_address <= fetch_addr;
            mem_read    <= 1'b1;
            state_q     <= StFetch;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
